// File: rtl/top_pkg.sv
// Shared constants and types for the counting loop: data width, FSM states, reset values.
package top_pkg;

    localparam int unsigned DW = 8;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

    localparam logic [DW-1:0] I_RST  = 8'd1;
    localparam logic [DW-1:0] SN_RST = '0;

endpackage

// File: rtl/top_inv_checker.sv
// Sticky invariant checker for the counting loop: flags any cycle where sn != i-1 or sn > N.
module top_inv_checker
    import top_pkg::*;
#(
    parameter logic [DW-1:0] N = 8'd100
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [DW-1:0] i_i,
    input  logic [DW-1:0] sn_i,
    output logic          inv_err_o
);

    logic err_q, err_d;
    logic violation;

    always_comb begin
        violation = (sn_i != (i_i - 8'd1)) || (sn_i > N);
        err_d     = err_q | violation;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign inv_err_o = err_q;

endmodule

// File: rtl/top.sv
// Counting loop: i and sn advance together while selector is high until i exceeds N.
// Optional invariant checker is built when TOP_INV_CHECK_EN is defined.
module top
    import top_pkg::*;
#(
    parameter logic [DW-1:0] N = 8'd100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          selector,
    output logic [DW-1:0] i,
    output logic [DW-1:0] sn,
    output logic          done,
    output logic          inv_err
);

    state_e        state_q, state_d;
    logic [DW-1:0] i_q, i_d;
    logic [DW-1:0] sn_q, sn_d;
    logic          done_q;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        sn_d    = sn_q;
        case (state_q)
            RUN: begin
                // Exit test has priority over selector so the loop ends at i == N+1.
                if (i_q > N) begin
                    state_d = DONE;
                end else if (selector) begin
                    i_d  = i_q + 8'd1;
                    sn_d = sn_q + 8'd1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            i_q     <= I_RST;
            sn_q    <= SN_RST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            sn_q    <= sn_d;
            done_q  <= (state_d == DONE);
        end
    end

    assign i    = i_q;
    assign sn   = sn_q;
    assign done = done_q;

`ifdef TOP_INV_CHECK_EN
    top_inv_checker #(
        .N(N)
    ) u_inv_checker (
        .clk_i     (clk),
        .rst_ni    (rst),
        .i_i       (i_q),
        .sn_i      (sn_q),
        .inv_err_o (inv_err)
    );
`else
    assign inv_err = 1'b0;
`endif

endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for top with N=100.
module tb_top;

    logic       clk;
    logic       rst;
    logic       selector;
    logic [7:0] i;
    logic [7:0] sn;
    logic       done;
    logic       inv_err;

    int unsigned pass_cnt;
    int unsigned total_cnt;

    top #(.N(8'd100)) dut (
        .clk      (clk),
        .rst      (rst),
        .selector (selector),
        .i        (i),
        .sn       (sn),
        .done     (done),
        .inv_err  (inv_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply reset between edges and release it on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        selector = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive selector on the falling edge, then wait for the rising edge plus #1.
    task automatic step(input logic sel);
        @(negedge clk);
        selector = sel;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        selector = 1'b0;
        #1;
        total_cnt++;
        if ({i, sn, done, inv_err} !== {8'd1, 8'd0, 1'b0, 1'b0})
            $display("FAIL reset: got i=%0d sn=%0d done=%b inv_err=%b, want i=1 sn=0 done=0 inv_err=0",
                     i, sn, done, inv_err);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_hold();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(1'b0);
            total_cnt++;
            if ({i, sn, done} !== {8'd1, 8'd0, 1'b0})
                $display("FAIL hold[%0d]: got i=%0d sn=%0d done=%b, want i=1 sn=0 done=0", k, i, sn, done);
            else pass_cnt++;
        end
    endtask

    task automatic test_count();
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            step(1'b1);
            total_cnt++;
            if (i !== 8'(k + 1) || sn !== 8'(k) || done !== 1'b0)
                $display("FAIL count[%0d]: got i=%0d sn=%0d done=%b, want i=%0d sn=%0d done=0",
                         k, i, sn, done, k + 1, k);
            else pass_cnt++;
        end
        step(1'b1);
        total_cnt++;
        if ({i, sn, done} !== {8'd101, 8'd100, 1'b1})
            $display("FAIL count_exit: got i=%0d sn=%0d done=%b, want i=101 sn=100 done=1", i, sn, done);
        else pass_cnt++;
    endtask

    task automatic test_done_hold();
        for (int k = 0; k < 50; k++) begin
            step(k[0]);
            total_cnt++;
            if ({i, sn, done} !== {8'd101, 8'd100, 1'b1})
                $display("FAIL done_hold[%0d]: got i=%0d sn=%0d done=%b, want i=101 sn=100 done=1",
                         k, i, sn, done);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 49; k++) step(1'b1);
        total_cnt++;
        if (i !== 8'd50 || sn !== 8'd49)
            $display("FAIL mid_reset_pre: got i=%0d sn=%0d, want i=50 sn=49", i, sn);
        else pass_cnt++;
        // clk is high here (1 after posedge); assert reset mid-high-phase.
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({i, sn, done} !== {8'd1, 8'd0, 1'b0})
            $display("FAIL mid_reset_async: got i=%0d sn=%0d done=%b, want i=1 sn=0 done=0", i, sn, done);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        selector = 1'b1;
        #1;
        total_cnt++;
        if (i !== 8'd1 || sn !== 8'd0)
            $display("FAIL mid_reset_release: got i=%0d sn=%0d, want i=1 sn=0", i, sn);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if (i !== 8'd2 || sn !== 8'd1)
            $display("FAIL mid_reset_first_edge: got i=%0d sn=%0d, want i=2 sn=1", i, sn);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int unsigned hi_cnt;
        logic        sel;
        logic [7:0]  exp_i;
        logic        exp_done;
        do_reset();
        hi_cnt = 0;
        exp_done = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            sel = 1'($urandom_range(0, 1));
            if (exp_i_gt(hi_cnt)) exp_done = 1'b1;
            else if (sel) hi_cnt++;
            step(sel);
            exp_i = 8'(1 + hi_cnt);
            total_cnt++;
            if (i !== exp_i || sn !== 8'(exp_i - 8'd1) || done !== exp_done || inv_err !== 1'b0)
                $display("FAIL random[%0d]: got i=%0d sn=%0d done=%b inv_err=%b, want i=%0d sn=%0d done=%b inv_err=0",
                         k, i, sn, done, inv_err, exp_i, exp_i - 8'd1, exp_done);
            else pass_cnt++;
        end
        total_cnt++;
        if (hi_cnt >= 101 && done !== 1'b1)
            $display("FAIL random_final: got done=%b, want 1 after %0d high samples", done, hi_cnt);
        else pass_cnt++;
    endtask

    // Loop has exited once i (1 + accepted highs) exceeds N=100.
    function automatic logic exp_i_gt(input int unsigned highs);
        return (1 + highs) > 100;
    endfunction

`ifdef TOP_INV_CHECK_EN
    task automatic test_inv_err();
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1);
        @(negedge clk);
        selector = 1'b0;
        force dut.sn_q = 8'd9;
        @(posedge clk);
        #1;
        release dut.sn_q;
        total_cnt++;
        if (inv_err !== 1'b1)
            $display("FAIL inv_err_set: got inv_err=%b, want 1", inv_err);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            step(1'b0);
            total_cnt++;
            if (inv_err !== 1'b1)
                $display("FAIL inv_err_sticky[%0d]: got inv_err=%b, want 1", k, inv_err);
            else pass_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (inv_err !== 1'b0)
            $display("FAIL inv_err_clear: got inv_err=%b, want 0", inv_err);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
    endtask
`endif

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        selector  = 1'b0;
        test_reset();
        test_hold();
        test_count();
        test_done_hold();
        test_mid_reset();
        test_random();
`ifdef TOP_INV_CHECK_EN
        test_inv_err();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The module SHALL have parameter N, default 8'd100, meaning the loop bound, legal range 1..254.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port selector, input, 1 bit: iteration enable, sampled at the rising clk edge.
REQ-005 The module SHALL have port i, output, 8 bits: loop index register.
REQ-006 The module SHALL have port sn, output, 8 bits: accumulated sum register.
REQ-007 The module SHALL have port done, output, 1 bit: high once the loop has exited.
REQ-008 The module SHALL have port inv_err, output, 1 bit: sticky invariant-violation flag.

Function
REQ-009 The module SHALL use a two-state FSM: RUN and DONE.
REQ-010 In RUN with selector=1 and i<=N, each clk edge SHALL set i<=i+1 and sn<=sn+1 in the same cycle (latency 1).
REQ-011 In RUN with selector=0, i and sn SHALL hold.
REQ-012 In RUN, when i>N is sampled (i==N+1), the FSM SHALL move to DONE on that edge, regardless of selector; i and sn hold.
REQ-013 In DONE, i, sn and done SHALL hold indefinitely until reset; selector is ignored.
REQ-014 done SHALL be a registered output equal to (state==DONE).
REQ-015 Arithmetic SHALL be unsigned 8-bit; with N<=254, i never exceeds 255 and no wrap occurs.
REQ-016 Invariant: sn == i-1 on every cycle; final values in DONE SHALL be i=N+1 and sn=N.
REQ-017 Outputs SHALL be driven directly from registers, with no combinational path from selector.

Reset
REQ-018 When rst=0, the module SHALL immediately, without waiting for clk, set i=1, sn=0, state=RUN, done=0 and inv_err=0.
REQ-019 Reset asserted mid-loop or in DONE SHALL restart from REQ-018 values; the first update SHALL occur on the first clk edge after rst rises.

Configuration
REQ-020 With macro TOP_INV_CHECK_EN defined, the module SHALL include a checker that sets inv_err sticky-high on the edge after any cycle where sn != i-1, or sn > N.
REQ-021 Without TOP_INV_CHECK_EN, inv_err SHALL be tied to 0 and no checker logic SHALL be built; the port list SHALL be unchanged.

Structure
REQ-022 Package top_pkg SHALL hold the data-width constant (8), the state enum (RUN, DONE) and the reset values of i and sn.
REQ-023 The checker SHALL be a sub-module top_inv_checker, instantiated only under TOP_INV_CHECK_EN.

Verification
REQ-024 Release reset, hold selector=1 for 100 cycles with N=100: i=101 and sn=100 after 100 edges; done=1 after the next edge.
REQ-025 With selector=0 for 20 cycles after reset: i=1, sn=0 and done=0 throughout.
REQ-026 With random selector for 1000 cycles: sn==i-1 every cycle, done=1 once 101 high samples have occurred, and inv_err=0 throughout.
REQ-027 Assert rst low mid-clock at i=50: i=1 and sn=0 immediately, before the next clk edge.
REQ-028 In DONE, toggle selector for 50 cycles: i=101, sn=100 and done=1 unchanged.
REQ-029 With TOP_INV_CHECK_EN and sn forced to i+3 for one cycle: inv_err=1 on the next edge and stays 1 until reset.
